adder_sequencer: RTL and testbench

Nibble-serial, multi-precision add/subtract engine that time-shares a single 4-bit carry-chained adder datapath between two requesters. It arbitrates round-robin, accepts a WIDTH-bit operation, and processes one nibble per clock, LSB first, carrying between nibbles through a register. It returns the sum, carry-out and signed overflow on a valid/ready result port. It sits between client logic and the 4-bit ripple adder built from the team's structural full-adder cells; the nibble adder has an explicit carry-in.

---
 rtl/adder_sequencer_if.sv | 35 +++
 rtl/adder_sequencer.sv | 104 ++++++++++
 tb/tb_adder_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/adder_sequencer_if.sv
// rtl/adder_sequencer_if.sv - requester and result handshake bundle for adder_sequencer
interface adder_sequencer_if #(parameter int WIDTH = 16);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [WIDTH-1:0] res_sum;
    logic             res_carryout;
    logic             res_overflow;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_sum, res_carryout, res_overflow
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_sum, res_carryout, res_overflow
    );
endinterface

// File: rtl/adder_sequencer.sv
// rtl/adder_sequencer.sv - nibble-serial add/subtract engine shared round-robin by two requesters
module adder_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    adder_sequencer_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [KW-1:0]    k;
    logic             carry, id_q, prio, co_q, ov_q;
    logic             grant0, grant1, accept, last_nib;
    logic [3:0]       na, nb, ns;
    logic [4:0]       c;

    assign last_nib = (k == KW'(NIBBLES - 1));
    assign accept   = grant0 | grant1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Grants are gated by reset so nothing can be accepted while state is being cleared
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    grant0 = bus.req0_valid & (!bus.req1_valid | !prio);
                    grant1 = bus.req1_valid & (!bus.req0_valid | prio);
                end
                if (grant0 | grant1) state_nxt = RUN;
            end
            RUN:     if (last_nib) state_nxt = DONE;
            DONE:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // 4-bit ripple adder; c[3] is the carry into the MSB of the top nibble
    always_comb begin
        a_sh = a_q >> {k, 2'b00};
        b_sh = b_q >> {k, 2'b00};
        na   = a_sh[3:0];
        nb   = b_sh[3:0];
        c    = '0;
        ns   = '0;
        c[0] = carry;
        for (int i = 0; i < 4; i++) begin
            ns[i]   = na[i] ^ nb[i] ^ c[i];
            c[i+1]  = (na[i] & nb[i]) | (c[i] & (na[i] ^ nb[i]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            k     <= '0;
            carry <= 1'b0;
            id_q  <= 1'b0;
            prio  <= 1'b0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= grant1 ? bus.req1_a : bus.req0_a;
            if (grant1) b_q <= bus.req1_sub ? ~bus.req1_b : bus.req1_b;
            else        b_q <= bus.req0_sub ? ~bus.req0_b : bus.req0_b;
            carry <= grant1 ? bus.req1_sub : bus.req0_sub;
            id_q  <= grant1;
            prio  <= grant0;
            k     <= '0;
        end else if (state == RUN) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (k == KW'(n)) sum_q[4*n +: 4] <= ns;
            end
            carry <= c[4];
            k     <= last_nib ? '0 : k + 1'b1;
            if (last_nib) begin
                co_q <= c[4];
                ov_q <= c[4] ^ c[3];
            end
        end
    end

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.res_valid    = (state == DONE);
    assign bus.res_id       = id_q;
    assign bus.res_sum      = sum_q;
    assign bus.res_carryout = co_q;
    assign bus.res_overflow = ov_q;
endmodule

// File: tb/tb_adder_sequencer.sv
// tb/tb_adder_sequencer.sv - directed self-checking bench for adder_sequencer
module tb_adder_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    adder_sequencer_if #(.WIDTH(16)) bus ();

    adder_sequencer #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Starts at a negedge; returns at the negedge after the accepting edge with valid dropped
    task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b, input logic sub);
        int t;
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
        end
        t = 0;
        #1;
        while (!(id ? bus.req1_ready : bus.req0_ready) && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("grant", id ? bus.req1_ready : bus.req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic eid, input logic [15:0] esum,
                           input logic eco, input logic eov);
        int n;
        wait_valid(n);
        check({tag, "_lat"}, n, 4);
        check({tag, "_id"}, bus.res_id, eid);
        check({tag, "_sum"}, bus.res_sum, esum);
        check({tag, "_co"}, bus.res_carryout, eco);
        check({tag, "_ov"}, bus.res_overflow, eov);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_drop"}, bus.res_valid, 0);
    endtask

    initial begin
        int n;
        int last_acc;
        int nres;
        int nacc;
        logic eid;

        reset = 1'b1;
        bus.res_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 16'h7FFF; bus.req0_b = 16'h0001; bus.req0_sub = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 16'h0003; bus.req1_b = 16'h0005; bus.req1_sub = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_r0", bus.req0_ready, 0);
        check("rst_r1", bus.req1_ready, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_id", bus.res_id, 0);
        check("rst_sum", bus.res_sum, 0);
        check("rst_co", bus.res_carryout, 0);
        check("rst_ov", bus.res_overflow, 0);

        reset = 1'b0;
        #1;
        check("rel_r0", bus.req0_ready, 1);
        check("rel_r1", bus.req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        check("run_r1", bus.req1_ready, 0);

        // 0x7FFF + 1 with result backpressure while requester 1 waits
        wait_valid(n);
        check("ovf_lat", n, 4);
        check("ovf_id", bus.res_id, 0);
        check("ovf_sum", bus.res_sum, 16'h8000);
        check("ovf_co", bus.res_carryout, 0);
        check("ovf_ov", bus.res_overflow, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", bus.res_valid, 1);
            check("bp_sum", bus.res_sum, 16'h8000);
            check("bp_id", bus.res_id, 0);
            check("bp_ov", bus.res_overflow, 1);
            check("bp_r0", bus.req0_ready, 0);
            check("bp_r1", bus.req1_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("bp_drop", bus.res_valid, 0);
        check("bp_next_r1", bus.req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        collect("sub35", 1, 16'hFFFE, 0, 0);

        issue(0, 16'hFFFF, 16'h0001, 0);
        collect("wrap", 0, 16'h0000, 1, 0);
        issue(1, 16'h8000, 16'h0001, 1);
        collect("subov", 1, 16'h7FFF, 1, 1);

        // Continuous contention with res_ready tied high
        bus.req0_a = 16'h0001; bus.req0_b = 16'h0002; bus.req0_sub = 1'b0; bus.req0_valid = 1'b1;
        bus.req1_a = 16'h0010; bus.req1_b = 16'h0001; bus.req1_sub = 1'b1; bus.req1_valid = 1'b1;
        bus.res_ready = 1'b1;
        last_acc = 0; nres = 0; nacc = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (bus.req0_ready | bus.req1_ready) begin
                check("rr_one", {bus.req0_ready, bus.req1_ready} == 2'b11, 0);
                check("rr_grant", bus.req1_ready, nacc[0]);
                if (nacc > 0) check("rr_space", cyc - last_acc, 6);
                last_acc = cyc;
                nacc++;
            end
            if (bus.res_valid) begin
                eid = nres[0];
                check("rr_id", bus.res_id, eid);
                check("rr_sum", bus.res_sum, eid ? 16'h000F : 16'h0003);
                check("rr_co", bus.res_carryout, eid);
                nres++;
            end
            if (nres == 4) break;
            @(negedge clk);
        end
        check("rr_count", nres, 4);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("rr_drop", bus.res_valid, 0);

        // Abort after two nibbles, then rerun the same operation
        issue(0, 16'h1234, 16'h1111, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_valid", bus.res_valid, 0);
        check("abort_sum", bus.res_sum, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_idle", bus.res_valid, 0);
        @(negedge clk);
        issue(0, 16'h1234, 16'h1111, 0);
        collect("rerun", 0, 16'h2345, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
